dmem_mmio: RTL

Parametrised data memory for the single-cycle core. It provides a word-addressed RAM with byte-enable writes and a memory-mapped UART transmitter. The transmitter has a TX FIFO, a readable status register and an overflow flag. The core's load/store path connects here directly, and `tx` is the board serial output pin.

---
 rtl/dmem_mmio.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word-addressed RAM with byte-lane stores,
// plus a memory-mapped 8N1 UART transmitter fed from a TX FIFO.
module dmem_mmio #(
  parameter int RAM_WORDS     = 64,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int CLOCK_DIVIDE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_busy
);
  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = $clog2(TX_FIFO_DEPTH + 1);
  localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

  localparam logic [31:0] TXDATA_ADDR = 32'hF000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hF000_0004;
  localparam logic [31:0] CTRL_ADDR   = 32'hF000_0008;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [31:0]      ram  [RAM_WORDS];
  logic [7:0]       fifo [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  state_t           state;
  logic [DIV_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;

  logic             is_mmio, fifo_empty, fifo_full, bit_done;
  logic             push_req, push_ok, pop, clr_ovf;
  logic [IDX_W-1:0] word_idx;

  assign is_mmio    = (addr[31:28] == 4'hF);
  assign word_idx   = addr[IDX_W+1:2];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push_req   = write_enable && (addr == TXDATA_ADDR);
  assign push_ok    = push_req && !fifo_full;
  assign clr_ovf    = write_enable && (addr == CTRL_ADDR) && write_data[0];
  assign bit_done   = (bit_cnt == DIV_LAST);
  // The serializer takes the FIFO head when idle or exactly at the end of a stop bit.
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

  // NOTE: storage arrays carry no reset; contents must survive rst and a reset
  // term would turn the RAM into discrete flops.
  always_ff @(posedge clk) begin
    if (!rst && write_enable && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[word_idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
    if (!rst && push_ok) fifo[wr_ptr] <= write_data[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every block
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shifter <= fifo[rd_ptr];
            bit_cnt <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shifter[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (pop) begin
              shifter <= fifo[rd_ptr];
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns read_data and no latch is inferred.
    read_data = '0;
    if (!is_mmio) begin
      read_data = ram[word_idx];
    end else if (addr == STATUS_ADDR) begin
      read_data[0]    = tx_busy;
      read_data[1]    = fifo_full;
      read_data[2]    = fifo_empty;
      read_data[3]    = overflow;
      read_data[15:8] = 8'(count);
    end
  end
endmodule
